// File: rtl/ts_descriptor_fetch_if.sv
// Bus bundle for ts_descriptor_fetch: scheduler request, cache write, FLM hand-off and status.
// master = environment side (scheduler / buffer manager / FLM), slave = the fetch block.
interface ts_descriptor_fetch_if #(
   parameter int DESC_W = 45,
   parameter int ADDR_W = 5
) ();
   logic [ADDR_W-1:0]      iv_ts_injection_addr;
   logic                   i_ts_injection_addr_wr;
   logic                   o_ts_injection_addr_ack;
   logic [DESC_W-1:0]      iv_ts_desc_wdata;
   logic [ADDR_W-1:0]      iv_ts_desc_waddr;
   logic                   i_ts_desc_wr;
   logic [DESC_W-1:0]      ov_ts_descriptor;
   logic                   o_ts_descriptor_wr;
   logic                   i_ts_descriptor_ack;
   logic [(2**ADDR_W)-1:0] ov_ts_desc_valid_map;
   logic [15:0]            ov_ts_miss_cnt;
   logic [15:0]            ov_ts_overwrite_cnt;
   logic [1:0]             ov_fetch_state;

   modport master (
      output iv_ts_injection_addr, i_ts_injection_addr_wr,
      output iv_ts_desc_wdata, iv_ts_desc_waddr, i_ts_desc_wr,
      output i_ts_descriptor_ack,
      input  o_ts_injection_addr_ack, ov_ts_descriptor, o_ts_descriptor_wr,
      input  ov_ts_desc_valid_map, ov_ts_miss_cnt, ov_ts_overwrite_cnt, ov_fetch_state
   );

   modport slave (
      input  iv_ts_injection_addr, i_ts_injection_addr_wr,
      input  iv_ts_desc_wdata, iv_ts_desc_waddr, i_ts_desc_wr,
      input  i_ts_descriptor_ack,
      output o_ts_injection_addr_ack, ov_ts_descriptor, o_ts_descriptor_wr,
      output ov_ts_desc_valid_map, ov_ts_miss_cnt, ov_ts_overwrite_cnt, ov_fetch_state
   );
endinterface

// File: rtl/ts_descriptor_fetch.sv
// TS descriptor cache between injection scheduler and FLM; a hit reads the cached entry and hands it off.
// Define TS_DESC_HOLD_EN to keep entries valid after a hit (periodic re-injection).
module ts_descriptor_fetch #(
   parameter int DESC_W = 45,
   parameter int ADDR_W = 5
) (
   input logic                  i_clk,
   input logic                  i_rst,
   ts_descriptor_fetch_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      TX      = 2'd2
   } state_e;

   state_e            state_q;
   logic [DESC_W-1:0] mem [DEPTH];
   logic [DESC_W-1:0] rdata_q;
   logic [DESC_W-1:0] desc_q;
   logic              desc_wr_q;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [15:0]       miss_q, miss_d;
   logic [15:0]       ovw_q, ovw_d;
`ifdef TS_DESC_HOLD_EN
   logic [DEPTH-1:0]  held_q, held_d;
`endif

   logic [ADDR_W-1:0] rd_addr_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic              conflict_s, req_s, hit_s, miss_s, overwrite_s;

   assign rd_addr_s = bus.iv_ts_injection_addr;
   assign wr_addr_s = bus.iv_ts_desc_waddr;

   // Request decode; a same-address cache write defers the request so the new data lands first.
   always_comb begin
      conflict_s = bus.i_ts_desc_wr && (wr_addr_s == rd_addr_s);
      req_s      = !i_rst && (state_q == IDLE) && bus.i_ts_injection_addr_wr && !conflict_s;
      hit_s      = req_s && valid_q[rd_addr_s];
      miss_s     = req_s && !valid_q[rd_addr_s];
`ifdef TS_DESC_HOLD_EN
      overwrite_s = valid_q[wr_addr_s] && !held_q[wr_addr_s];
`else
      overwrite_s = valid_q[wr_addr_s];
`endif
   end

   // Next-state for the validity map and the saturating statistics.
   always_comb begin
      valid_d = valid_q;
      miss_d  = miss_q;
      ovw_d   = ovw_q;
`ifdef TS_DESC_HOLD_EN
      held_d  = held_q;
      if (hit_s) begin
         held_d[rd_addr_s] = 1'b1;
      end else begin
         held_d[rd_addr_s] = held_q[rd_addr_s];
      end
`else
      if (hit_s) begin
         valid_d[rd_addr_s] = 1'b0;
      end else begin
         valid_d[rd_addr_s] = valid_q[rd_addr_s];
      end
`endif
      if (bus.i_ts_desc_wr) begin
         valid_d[wr_addr_s] = 1'b1;
`ifdef TS_DESC_HOLD_EN
         held_d[wr_addr_s] = 1'b0;
`endif
         if (overwrite_s && (ovw_q != 16'hFFFF)) begin
            ovw_d = ovw_q + 16'd1;
         end else begin
            ovw_d = ovw_q;
         end
      end else begin
         ovw_d = ovw_q;
      end
      if (miss_s && (miss_q != 16'hFFFF)) begin
         miss_d = miss_q + 16'd1;
      end else begin
         miss_d = miss_q;
      end
   end

   // Status registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= {DEPTH{1'b0}};
         miss_q  <= 16'd0;
         ovw_q   <= 16'd0;
`ifdef TS_DESC_HOLD_EN
         held_q  <= {DEPTH{1'b0}};
`endif
      end else begin
         valid_q <= valid_d;
         miss_q  <= miss_d;
         ovw_q   <= ovw_d;
`ifdef TS_DESC_HOLD_EN
         held_q  <= held_d;
`endif
      end
   end

   // Descriptor storage array; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (bus.i_ts_desc_wr) begin
         mem[wr_addr_s] <= bus.iv_ts_desc_wdata;
      end
   end

   // Registered read port, loaded only on an accepted hit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q <= {DESC_W{1'b0}};
      end else if (hit_s) begin
         rdata_q <= mem[rd_addr_s];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   // Fetch FSM with registered hand-off outputs; the descriptor holds after hand-off.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         desc_q    <= {DESC_W{1'b0}};
         desc_wr_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit_s) begin
                  state_q <= RD_WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_WAIT: begin
               desc_q    <= rdata_q;
               desc_wr_q <= 1'b1;
               state_q   <= TX;
            end
            TX: begin
               if (bus.i_ts_descriptor_ack) begin
                  desc_wr_q <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  state_q   <= TX;
               end
            end
            default: begin
               desc_wr_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_ts_injection_addr_ack = req_s;
   assign bus.ov_ts_descriptor        = desc_q;
   assign bus.o_ts_descriptor_wr      = desc_wr_q;
   assign bus.ov_ts_desc_valid_map    = valid_q;
   assign bus.ov_ts_miss_cnt          = miss_q;
   assign bus.ov_ts_overwrite_cnt     = ovw_q;
   assign bus.ov_fetch_state          = state_q;
endmodule

// File: tb/tb_ts_descriptor_fetch.sv
// Directed self-checking bench for ts_descriptor_fetch; honours TS_DESC_HOLD_EN when defined.
module tb_ts_descriptor_fetch;
   localparam int DESC_W = 45;
   localparam int ADDR_W = 5;
`ifdef TS_DESC_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_vec = 0;
   int          n_miscmp = 0;
   logic [31:0] exp_valid;

   ts_descriptor_fetch_if #(.DESC_W(DESC_W), .ADDR_W(ADDR_W)) bus ();

   ts_descriptor_fetch #(.DESC_W(DESC_W), .ADDR_W(ADDR_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic cache_wr(input logic [4:0] a, input logic [44:0] d);
      bus.iv_ts_desc_waddr = a;
      bus.iv_ts_desc_wdata = d;
      bus.i_ts_desc_wr     = 1'b1;
      tick();
      bus.i_ts_desc_wr     = 1'b0;
   endtask

   // Request a valid entry, then accept the descriptor on its first TX cycle.
   task automatic hit_cycle(input logic [4:0] a, input logic [44:0] d, input string tag);
      bus.iv_ts_injection_addr   = a;
      bus.i_ts_injection_addr_wr = 1'b1;
      settle();
      check_val({tag, "_ack"}, 64'(bus.o_ts_injection_addr_ack), 64'd1);
      tick();
      bus.i_ts_injection_addr_wr = 1'b0;
      settle();
      check_val({tag, "_rdwait"}, 64'(bus.ov_fetch_state), 64'd1);
      tick();
      settle();
      check_val({tag, "_wr"}, 64'(bus.o_ts_descriptor_wr), 64'd1);
      check_val({tag, "_desc"}, 64'(bus.ov_ts_descriptor), 64'(d));
      bus.i_ts_descriptor_ack = 1'b1;
      tick();
      bus.i_ts_descriptor_ack = 1'b0;
      settle();
      check_val({tag, "_idle"}, 64'(bus.ov_fetch_state), 64'd0);
      check_val({tag, "_wrlow"}, 64'(bus.o_ts_descriptor_wr), 64'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.iv_ts_injection_addr   = 5'd0;
      bus.i_ts_injection_addr_wr = 1'b0;
      bus.iv_ts_desc_wdata       = 45'd0;
      bus.iv_ts_desc_waddr       = 5'd0;
      bus.i_ts_desc_wr           = 1'b0;
      bus.i_ts_descriptor_ack    = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      settle();
      check_val("rst_ack",   64'(bus.o_ts_injection_addr_ack), 64'd0);
      check_val("rst_wr",    64'(bus.o_ts_descriptor_wr), 64'd0);
      check_val("rst_desc",  64'(bus.ov_ts_descriptor), 64'd0);
      check_val("rst_valid", 64'(bus.ov_ts_desc_valid_map), 64'd0);
      check_val("rst_miss",  64'(bus.ov_ts_miss_cnt), 64'd0);
      check_val("rst_ovw",   64'(bus.ov_ts_overwrite_cnt), 64'd0);
      check_val("rst_state", 64'(bus.ov_fetch_state), 64'd0);

      // Basic hit on addr 3 with FLM ack held off until T+4
      cache_wr(5'd3, 45'h1_2345_6789A);
      exp_valid = 32'h0000_0008;
      settle();
      check_val("w3_valid", 64'(bus.ov_ts_desc_valid_map), 64'(exp_valid));
      bus.iv_ts_injection_addr   = 5'd3;
      bus.i_ts_injection_addr_wr = 1'b1;
      settle();
      check_val("h3_ack_T", 64'(bus.o_ts_injection_addr_ack), 64'd1);
      tick();
      bus.i_ts_injection_addr_wr = 1'b0;
      settle();
      if (!HOLD) exp_valid = 32'h0000_0000;
      check_val("h3_state_T1", 64'(bus.ov_fetch_state), 64'd1);
      check_val("h3_wr_T1",    64'(bus.o_ts_descriptor_wr), 64'd0);
      check_val("h3_valid",    64'(bus.ov_ts_desc_valid_map), 64'(exp_valid));
      tick();
      settle();
      check_val("h3_wr_T2",   64'(bus.o_ts_descriptor_wr), 64'd1);
      check_val("h3_desc_T2", 64'(bus.ov_ts_descriptor), 64'h1_2345_6789A);
      tick();
      tick();
      bus.i_ts_descriptor_ack = 1'b1;
      settle();
      check_val("h3_wr_T4", 64'(bus.o_ts_descriptor_wr), 64'd1);
      tick();
      bus.i_ts_descriptor_ack = 1'b0;
      settle();
      check_val("h3_wr_T5",    64'(bus.o_ts_descriptor_wr), 64'd0);
      check_val("h3_state_T5", 64'(bus.ov_fetch_state), 64'd0);
      check_val("h3_desc_hold", 64'(bus.ov_ts_descriptor), 64'h1_2345_6789A);

      // Misses on never-written addr 7, held continuously to saturate the counter
      bus.iv_ts_injection_addr   = 5'd7;
      bus.i_ts_injection_addr_wr = 1'b1;
      settle();
      check_val("m7_ack", 64'(bus.o_ts_injection_addr_ack), 64'd1);
      tick();
      settle();
      check_val("m7_cnt1",  64'(bus.ov_ts_miss_cnt), 64'd1);
      check_val("m7_state", 64'(bus.ov_fetch_state), 64'd0);
      check_val("m7_wr",    64'(bus.o_ts_descriptor_wr), 64'd0);
      repeat (65533) tick();
      settle();
      check_val("m7_cnt_fffe", 64'(bus.ov_ts_miss_cnt), 64'h0000_FFFE);
      tick();
      settle();
      check_val("m7_cnt_ffff", 64'(bus.ov_ts_miss_cnt), 64'h0000_FFFF);
      tick();
      bus.i_ts_injection_addr_wr = 1'b0;
      settle();
      check_val("m7_cnt_sat", 64'(bus.ov_ts_miss_cnt), 64'h0000_FFFF);

      // Double write to addr 5, hit returns the second data
      cache_wr(5'd5, 45'h0AAA_5555_1111);
      settle();
      check_val("w5_ovw0", 64'(bus.ov_ts_overwrite_cnt), 64'd0);
      cache_wr(5'd5, 45'h0ABC_DEF0_1234);
      settle();
      exp_valid = exp_valid | 32'h0000_0020;
      check_val("w5_ovw1",  64'(bus.ov_ts_overwrite_cnt), 64'd1);
      check_val("w5_valid", 64'(bus.ov_ts_desc_valid_map), 64'(exp_valid));
      hit_cycle(5'd5, 45'h0ABC_DEF0_1234, "h5");
      if (!HOLD) exp_valid = exp_valid & ~32'h0000_0020;
      check_val("h5_valid", 64'(bus.ov_ts_desc_valid_map), 64'(exp_valid));

      // Same-cycle write and request to addr 9
      cache_wr(5'd2, 45'h1555_0000_2222);
      exp_valid = exp_valid | 32'h0000_0004;
      bus.iv_ts_injection_addr   = 5'd9;
      bus.i_ts_injection_addr_wr = 1'b1;
      bus.iv_ts_desc_waddr       = 5'd9;
      bus.iv_ts_desc_wdata       = 45'h0999_0000_9999;
      bus.i_ts_desc_wr           = 1'b1;
      settle();
      check_val("c9_noack", 64'(bus.o_ts_injection_addr_ack), 64'd0);
      tick();
      bus.i_ts_desc_wr = 1'b0;
      settle();
      check_val("c9_ack", 64'(bus.o_ts_injection_addr_ack), 64'd1);
      tick();
      bus.i_ts_injection_addr_wr = 1'b0;
      settle();
      check_val("c9_state", 64'(bus.ov_fetch_state), 64'd1);
      tick();
      settle();
      check_val("c9_wr",   64'(bus.o_ts_descriptor_wr), 64'd1);
      check_val("c9_desc", 64'(bus.ov_ts_descriptor), 64'h0999_0000_9999);

      // Back-pressure: request addr 2 while the FLM stalls for 10 cycles
      bus.iv_ts_injection_addr   = 5'd2;
      bus.i_ts_injection_addr_wr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         settle();
         check_val("bp_noack", 64'(bus.o_ts_injection_addr_ack), 64'd0);
         tick();
      end
      bus.i_ts_descriptor_ack = 1'b1;
      settle();
      check_val("bp_noack_tx", 64'(bus.o_ts_injection_addr_ack), 64'd0);
      tick();
      bus.i_ts_descriptor_ack = 1'b0;
      settle();
      check_val("bp_idle", 64'(bus.ov_fetch_state), 64'd0);
      check_val("bp_ack",  64'(bus.o_ts_injection_addr_ack), 64'd1);
      tick();
      bus.i_ts_injection_addr_wr = 1'b0;
      tick();
      settle();
      if (!HOLD) exp_valid = exp_valid & ~32'h0000_0004;
      check_val("h2_state", 64'(bus.ov_fetch_state), 64'd2);
      check_val("h2_desc",  64'(bus.ov_ts_descriptor), 64'h1555_0000_2222);
      check_val("h2_valid", 64'(bus.ov_ts_desc_valid_map), 64'(exp_valid | (HOLD ? 32'h0000_0200 : 32'h0000_0000)));

      // Reset during TX aborts the hand-off
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check_val("rtx_wr",    64'(bus.o_ts_descriptor_wr), 64'd0);
      check_val("rtx_desc",  64'(bus.ov_ts_descriptor), 64'd0);
      check_val("rtx_valid", 64'(bus.ov_ts_desc_valid_map), 64'd0);
      check_val("rtx_miss",  64'(bus.ov_ts_miss_cnt), 64'd0);
      check_val("rtx_ovw",   64'(bus.ov_ts_overwrite_cnt), 64'd0);
      check_val("rtx_state", 64'(bus.ov_fetch_state), 64'd0);
      check_val("rtx_ack",   64'(bus.o_ts_injection_addr_ack), 64'd0);

`ifdef TS_DESC_HOLD_EN
      // Held entry re-injected three times, rewrite of a held entry not counted
      cache_wr(5'd4, 45'h0444_4444_4444);
      for (int k = 0; k < 3; k++) begin
         hit_cycle(5'd4, 45'h0444_4444_4444, "hold4");
      end
      check_val("hold4_valid", 64'(bus.ov_ts_desc_valid_map), 64'h0000_0010);
      cache_wr(5'd4, 45'h0123_0000_0004);
      settle();
      check_val("hold4_ovw", 64'(bus.ov_ts_overwrite_cnt), 64'd0);
      hit_cycle(5'd4, 45'h0123_0000_0004, "hold4_new");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end
endmodule

// File: doc/ts_descriptor_fetch.md
Name: ts_descriptor_fetch

Overview:
- Sits directly downstream of the time-sensitive injection scheduler in the host receive path.
- Consumes the 5-bit injection address the scheduler issues each scheduled slot, using the addr/wr/ack handshake.
- Reads the cached TS descriptor for that address from a 32-entry descriptor RAM. The host receive buffer manager fills this RAM.
- Hands the descriptor to the forwarding lookup module (FLM) with a wr/ack handshake, and tracks per-entry validity and miss/overwrite statistics.

Parameters:
DESC_W, 45, descriptor width in bits
ADDR_W, 5, descriptor RAM address width; depth is 2**ADDR_W = 32

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
iv_ts_injection_addr  in  ADDR_W  descriptor index requested by scheduler
i_ts_injection_addr_wr  in  1  request; scheduler holds it and the address until ack
o_ts_injection_addr_ack  out  1  one-cycle pulse: request consumed (hit or miss)
iv_ts_desc_wdata  in  DESC_W  descriptor to cache
iv_ts_desc_waddr  in  ADDR_W  cache index
i_ts_desc_wr  in  1  cache write strobe
ov_ts_descriptor  out  DESC_W  descriptor to FLM
o_ts_descriptor_wr  out  1  descriptor valid to FLM; held until ack
i_ts_descriptor_ack  in  1  FLM accepted descriptor
ov_ts_desc_valid_map  out  32  per-entry valid bits
ov_ts_miss_cnt  out  16  requests to invalid entries; saturating
ov_ts_overwrite_cnt  out  16  writes to already-valid entries; saturating
ov_fetch_state  out  2  FSM state for debug

Behaviour:
- Reset (i_rst high at a clock edge) applies to all flops; RAM contents are not cleared.
  - ack=0, descriptor_wr=0, ov_ts_descriptor=0, valid_map=0, both counters=0, state=IDLE.
  - Reset mid-operation aborts any fetch or hand-off with no ack.
- Descriptor RAM: simple dual-port, registered read, 1-cycle read latency.
- Cache write: i_ts_desc_wr writes the RAM and sets valid_map[waddr]. If that bit was already 1, ov_ts_overwrite_cnt increments, saturating at 0xFFFF.
- FSM states, encoded in ov_fetch_state: IDLE=0, RD_WAIT=1, TX=2. Code 3 is unused; if ever reached, go to IDLE.
- IDLE with i_ts_injection_addr_wr=1, at cycle T:
  - Same-address conflict: if i_ts_desc_wr=1 and iv_ts_desc_waddr==iv_ts_injection_addr, the request is not accepted this cycle (no ack). It retries the next cycle, so the write always lands first.
  - Miss: if valid_map[addr]=0, pulse ack at T, increment ov_ts_miss_cnt (saturating), stay IDLE.
  - Hit: pulse ack at T, issue the RAM read at addr, clear valid_map[addr], go to RD_WAIT.
  - A cache write to a different address in cycle T proceeds normally.
- RD_WAIT (T+1): RAM data available; register it into ov_ts_descriptor; go to TX.
- TX: o_ts_descriptor_wr=1 from cycle T+2, with ov_ts_descriptor stable.
  - On the cycle i_ts_descriptor_ack is sampled 1, descriptor_wr drops the next cycle and the FSM returns to IDLE.
  - Minimum hit-to-hit spacing is therefore 3 cycles.
- Scheduler requests arriving in RD_WAIT or TX are not acked until IDLE, which back-pressures the scheduler.
- ack is never asserted outside IDLE. ack and a state change happen in the same cycle.
- A write to an entry currently in flight (RD_WAIT/TX) sets its valid bit again. The in-flight descriptor keeps its latched value.
- ov_ts_descriptor holds its last value after hand-off; it is zeroed only by reset.

Optional Feature:
Macro TS_DESC_HOLD_EN.
- Defined: a hit does not clear valid_map[addr]. Entries stay valid for periodic re-injection every table period until rewritten or reset; ov_ts_overwrite_cnt does not count rewrites of held entries.
- Undefined: one-shot behaviour as described in Behaviour (a hit clears the entry).

Test Plan:
- Reset, write desc 0x1_2345_6789A to addr 3, request addr 3 at T → ack at T, descriptor_wr from T+2 with 0x1_2345_6789A; FLM ack at T+4 → wr low at T+5, valid_map[3]=0.
- Request addr 7 that was never written → single ack pulse, no descriptor_wr, miss_cnt=1; repeat 0x10000 times → miss_cnt saturates at 0xFFFF.
- Write addr 5 twice, then request addr 5 → overwrite_cnt=1, output carries the second data.
- In the same cycle, write addr 9 and request addr 9 (previously invalid) → no ack that cycle; ack the next cycle as a hit with the new data.
- Hold FLM ack low 10 cycles while the scheduler requests addr 2 → no ack to the scheduler until TX exits; assert i_rst during TX → all outputs 0 the next cycle, valid_map=0.
- With TS_DESC_HOLD_EN defined, request addr 4 three times → three hits with identical data, valid_map[4] stays 1.
